// File: rtl/game_pkg.sv
// Shared game types: pattern geometry, sequencer states and the symbol one-hot encoder.
`default_nettype none

package game_pkg;

  localparam int SYM_W     = 3;
  localparam int MAX_LEN   = 25;
  localparam int PATTERN_W = SYM_W * MAX_LEN;
  localparam int LEN_W     = 5;
  localparam int LED_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  function automatic logic [LED_W-1:0] sym_to_onehot(input logic [SYM_W-1:0] sym);
    return LED_W'(1) << sym;
  endfunction

  function automatic logic [SYM_W-1:0] get_sym(input logic [PATTERN_W-1:0] pat,
                                               input logic [LEN_W-1:0]     k);
    logic [PATTERN_W-1:0] shifted;
    shifted = pat >> (SYM_W * int'(k));
    return shifted[SYM_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/playback_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded period.
`default_nettype none

module playback_timer #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          clear,
  output logic          expire
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  // A period of N cycles spans counts N..1, so the final cycle is count==1.
  assign expire = (count == TW'(1));

endmodule

`default_nettype wire

// File: rtl/pattern_playback_sequencer.sv
// Timed one-hot playback of a stored symbol pattern onto the LEDs, with abort.
// Optional PLAYBACK_SPEEDUP_EN shortens each successive ON period down to a floor.
`default_nettype none

module pattern_playback_sequencer
  import game_pkg::*;
#(
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250
`ifdef PLAYBACK_SPEEDUP_EN
  ,
  parameter int SPEEDUP_STEP  = 16,
  parameter int MIN_ON_CYCLES = 100
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     length,
  input  logic [PATTERN_W-1:0] pattern,
  output logic [LED_W-1:0]     led,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     index
);

  localparam int BASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`ifdef PLAYBACK_SPEEDUP_EN
  localparam int MAX_CYC  = (MIN_ON_CYCLES > BASE_MAX) ? MIN_ON_CYCLES : BASE_MAX;
`else
  localparam int MAX_CYC  = BASE_MAX;
`endif
  localparam int TIMER_W  = $clog2(MAX_CYC + 1);

  seq_state_t           state, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LED_W-1:0]     led_d;
  logic                 busy_d, done_d;
  logic [LEN_W-1:0]     index_d;
  logic [LEN_W-1:0]     len_clamped;
  logic                 tmr_load, tmr_clear, tmr_expire;
  logic [TIMER_W-1:0]   tmr_value;
  logic [TIMER_W-1:0]   on_val;

  assign len_clamped = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;

`ifdef PLAYBACK_SPEEDUP_EN
  logic [LEN_W-1:0] next_k;
  int               step_dec;

  // ON period for the symbol about to be lit; saturates at MIN_ON_CYCLES.
  always_comb begin
    next_k   = (state == IDLE) ? '0 : index + LEN_W'(1);
    step_dec = int'(next_k) * SPEEDUP_STEP;
    if ((step_dec < ON_CYCLES) && ((ON_CYCLES - step_dec) > MIN_ON_CYCLES)) begin
      on_val = TIMER_W'(ON_CYCLES - step_dec);
    end else begin
      on_val = TIMER_W'(MIN_ON_CYCLES);
    end
  end
`else
  assign on_val = TIMER_W'(ON_CYCLES);
`endif

  playback_timer #(
    .TW (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .clear      (tmr_clear),
    .expire     (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      index <= '0;
    end else begin
      state <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      led   <= led_d;
      busy  <= busy_d;
      done  <= done_d;
      index <= index_d;
    end
  end

  // Next-state logic also produces next-cycle outputs so all outputs are registered.
  always_comb begin
    state_d   = state;
    pat_d     = pat_q;
    len_d     = len_q;
    led_d     = led;
    busy_d    = busy;
    done_d    = 1'b0;
    index_d   = index;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_value = '0;

    case (state)
      IDLE: begin
        led_d   = '0;
        busy_d  = 1'b0;
        index_d = '0;
        if (start) begin
          pat_d = pattern;
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ON;
            busy_d    = 1'b1;
            led_d     = sym_to_onehot(get_sym(pattern, '0));
            tmr_load  = 1'b1;
            tmr_value = on_val;
          end
        end
      end
      ON: begin
        if (tmr_expire) begin
          state_d   = OFF;
          led_d     = '0;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(OFF_CYCLES);
        end
      end
      OFF: begin
        if (tmr_expire) begin
          if (index == len_q - LEN_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            index_d = '0;
          end else begin
            state_d   = ON;
            index_d   = index + LEN_W'(1);
            led_d     = sym_to_onehot(get_sym(pat_q, index + LEN_W'(1)));
            tmr_load  = 1'b1;
            tmr_value = on_val;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d   = IDLE;
      led_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      index_d   = '0;
      pat_d     = pat_q;
      len_d     = len_q;
      tmr_load  = 1'b0;
      tmr_clear = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_playback_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-formula model.
`default_nettype none

module tb_pattern_playback_sequencer;

  localparam int ONC  = 4;
  localparam int OFFC = 2;
  localparam int PER  = ONC + OFFC;
  localparam int ML   = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  length = '0;
  logic [74:0] pattern = '0;
  logic [7:0]  led;
  logic        busy;
  logic        done;
  logic [4:0]  index;

  pattern_playback_sequencer #(
    .ON_CYCLES  (ONC),
    .OFF_CYCLES (OFFC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .length  (length),
    .pattern (pattern),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .index   (index)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model of one playback: started (start sampled) in cycle t0.
  bit          act = 1'b0;
  int          t0 = 0;
  int          mlen = 0;
  logic [74:0] mpat = '0;
  int          done_cyc = -1;
  int          ts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_idle();
    return !act || ((cyc - t0) > mlen * PER + 1);
  endfunction

  task automatic expect_now();
    int          t, k, ph;
    logic [7:0]  e_led;
    logic        e_busy, e_done;
    int          e_idx;
    logic [74:0] sh;
    e_led = '0; e_busy = 1'b0; e_done = 1'b0; e_idx = 0;
    if (act) begin
      t = cyc - t0;
      if (t >= 1 && t <= mlen * PER) begin
        k      = (t - 1) / PER;
        ph     = (t - 1) % PER;
        e_busy = 1'b1;
        e_idx  = k;
        sh     = mpat >> (3 * k);
        if (ph < ONC) e_led = 8'd1 << sh[2:0];
      end else if (t == mlen * PER + 1) begin
        e_done = 1'b1;
      end
    end
    check("led", 32'(led), 32'(e_led));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("index", 32'(index), e_idx);
    if (done === 1'b1) done_cyc = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    expect_now();
    if (abort) begin
      act = 1'b0;
    end else if (start && m_idle()) begin
      act  = 1'b1;
      t0   = cyc;
      mlen = (int'(length) > ML) ? ML : int'(length);
      mpat = pattern;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_start(input logic [4:0] len, input logic [74:0] pat);
    length   = len;
    pattern  = pat;
    start    = 1'b1;
    ts       = cyc;
    done_cyc = -1;
    step();
    start = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [74:0] p1;

  initial begin
    p1 = 75'({3'd7, 3'd0, 3'd5});
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_index", 32'(index), 0);
    rst_n = 1'b1;
    cyc   = 0;
    idle_steps(2);

    // 1: three symbols 5,0,7
    run_start(5'd3, p1);
    idle_steps(22);
    check("s1_done_lat", done_cyc - ts, 19);

    // 2: zero length
    run_start(5'd0, p1);
    idle_steps(3);
    check("s2_done_lat", done_cyc - ts, 1);

    // 3: abort in cycle 6, restart in cycle 8
    run_start(5'd3, p1);
    idle_steps(5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("s3_no_done", done_cyc, -1);
    run_start(5'd3, p1);
    idle_steps(22);
    check("s3_restart_lat", done_cyc - ts, 19);

    // 4: start re-pulsed with zero pattern in cycle 3 is ignored
    run_start(5'd3, p1);
    step();
    step();
    start   = 1'b1;
    pattern = '0;
    step();
    start = 1'b0;
    idle_steps(19);
    check("s4_done_lat", done_cyc - ts, 19);

    // 5: length 31 clamps to 25
    run_start(5'd31, {$urandom, $urandom, $urandom});
    idle_steps(155);
    check("s5_done_lat", done_cyc - ts, 151);

    // 6: async reset in cycle 2
    run_start(5'd3, p1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_led_async", 32'(led), 0);
    check("s6_busy_async", 32'(busy), 0);
    act = 1'b0;
    step();
    rst_n = 1'b1;
    idle_steps(25);
    check("s6_no_done", done_cyc, -1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 79) == 0);
      length  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      pattern = {$urandom, $urandom, $urandom};
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    idle_steps(160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
